// File: rtl/rs_param.sv
// rtl/rs_param.sv - parametrised reservation station with CDB capture and a registered issue stage
//
// Optional feature macro: RS_OLDEST_FIRST_EN (age matrix, oldest-ready-first issue).
// Without it, issue picks the lowest-index ready entry.
//
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (global enable), flush_in (sync clear)
//   disp_*      : dispatch request, ready handshake and instruction fields
//   cdb_*       : NCDB result broadcast channels, channel c at [c*W +: W]
//   iss_*       : registered issue stage (valid/ready)
//   count_out   : occupied entries, issue register excluded
//   almost_full_out : count_out >= DEPTH-FULL_MARGIN
module rs_param #(
  parameter int DEPTH       = 16,
  parameter int TAG_W       = 5,
  parameter int XLEN        = 32,
  parameter int OP_W        = 6,
  parameter int NCDB        = 2,
  parameter int FULL_MARGIN = 1,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic                    disp_valid_in,
  output logic                    disp_ready_out,
  input  logic [OP_W-1:0]         disp_op_in,
  input  logic [TAG_W-1:0]        disp_q1_in,
  input  logic [TAG_W-1:0]        disp_q2_in,
  input  logic [XLEN-1:0]         disp_v1_in,
  input  logic [XLEN-1:0]         disp_v2_in,
  input  logic [XLEN-1:0]         disp_pc_in,
  input  logic [XLEN-1:0]         disp_imm_in,
  input  logic [TAG_W-1:0]        disp_tag_in,
  input  logic [NCDB-1:0]         cdb_valid_in,
  input  logic [NCDB*TAG_W-1:0]   cdb_tag_in,
  input  logic [NCDB*XLEN-1:0]    cdb_data_in,
  output logic                    iss_valid_out,
  input  logic                    iss_ready_in,
  output logic [OP_W-1:0]         iss_op_out,
  output logic [XLEN-1:0]         iss_v1_out,
  output logic [XLEN-1:0]         iss_v2_out,
  output logic [XLEN-1:0]         iss_pc_out,
  output logic [XLEN-1:0]         iss_imm_out,
  output logic [TAG_W-1:0]        iss_tag_out,
  output logic [CW-1:0]           count_out,
  output logic                    almost_full_out
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] q1;
    logic [TAG_W-1:0] q2;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  v1;
    logic [XLEN-1:0]  v2;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
  } entry_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  v1;
    logic [XLEN-1:0]  v2;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
  } iss_t;

  logic [DEPTH-1:0] busy_q, busy_d;
  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic             iss_valid_q, iss_valid_d;
  iss_t             iss_q, iss_d;
  logic [CW-1:0]    count_q, count_d;

`ifdef RS_OLDEST_FIRST_EN
  // age_q[k][j] = 1 means entry k is younger than entry j.
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
`endif

  logic [DEPTH-1:0] ready;
  logic             sel_hit, free_hit, load, accept;
  logic [IW-1:0]    sel_idx, free_idx;
  entry_t           disp_e;

  // Returns {hit, data}; scanning downward lets the lowest channel win. Tag 0 never matches.
  function automatic logic [XLEN:0] cdb_lookup(input logic [TAG_W-1:0] t);
    logic [XLEN:0] r;
    r = '0;
    for (int c = NCDB - 1; c >= 0; c--) begin
      if (t != '0 && cdb_valid_in[c] && cdb_tag_in[c*TAG_W +: TAG_W] == t)
        r = {1'b1, cdb_data_in[c*XLEN +: XLEN]};
    end
    return r;
  endfunction

  function automatic entry_t wake(input entry_t e);
    entry_t        r;
    logic [XLEN:0] h;
    r = e;
    h = cdb_lookup(e.q1);
    if (h[XLEN]) begin
      r.q1 = '0;
      r.v1 = h[XLEN-1:0];
    end
    h = cdb_lookup(e.q2);
    if (h[XLEN]) begin
      r.q2 = '0;
      r.v2 = h[XLEN-1:0];
    end
    return r;
  endfunction

  assign disp_e = '{op: disp_op_in, q1: disp_q1_in, q2: disp_q2_in, tag: disp_tag_in,
                    v1: disp_v1_in, v2: disp_v2_in, pc: disp_pc_in, imm: disp_imm_in};

  // Readiness and selection look only at registered state, so a wakeup issues one edge later.
  always_comb begin
    ready    = '0;
    sel_hit  = 1'b0;
    sel_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      ready[i] = busy_q[i] && ent_q[i].q1 == '0 && ent_q[i].q2 == '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
`ifdef RS_OLDEST_FIRST_EN
      if (ready[i] && ((age_q[i] & ready) == '0)) begin
`else
      if (ready[i]) begin
`endif
        sel_hit = 1'b1;
        sel_idx = IW'(i);
      end
      if (!busy_q[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    busy_d      = busy_q;
    ent_d       = ent_q;
    iss_valid_d = iss_valid_q;
    iss_d       = iss_q;
    count_d     = count_q;
    load        = 1'b0;
    accept      = 1'b0;
`ifdef RS_OLDEST_FIRST_EN
    age_d       = age_q;
`endif
    if (flush_in) begin
      busy_d      = '0;
      iss_valid_d = 1'b0;
      count_d     = '0;
    end else if (rdy_in) begin
      load   = sel_hit && (!iss_valid_q || iss_ready_in);
      accept = disp_valid_in && disp_ready_out && free_hit;
      for (int i = 0; i < DEPTH; i++)
        ent_d[i] = wake(ent_q[i]);
      if (load) begin
        iss_d = '{op: ent_q[sel_idx].op, tag: ent_q[sel_idx].tag,
                  v1: ent_q[sel_idx].v1, v2: ent_q[sel_idx].v2,
                  pc: ent_q[sel_idx].pc, imm: ent_q[sel_idx].imm};
        iss_valid_d     = 1'b1;
        busy_d[sel_idx] = 1'b0;
      end else if (iss_valid_q && iss_ready_in) begin
        iss_valid_d = 1'b0;
      end
      // The free slot is never the one being issued (that slot is busy), so no conflict.
      if (accept) begin
        ent_d[free_idx]  = wake(disp_e);
        busy_d[free_idx] = 1'b1;
`ifdef RS_OLDEST_FIRST_EN
        for (int j = 0; j < DEPTH; j++)
          age_d[j][free_idx] = 1'b0;
        age_d[free_idx] = busy_q;
`endif
      end
      count_d = count_q + CW'(accept) - CW'(load);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q      <= '0;
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
`ifdef RS_OLDEST_FIRST_EN
        age_q[i] <= '0;
`endif
      end
    end else begin
      busy_q      <= busy_d;
      iss_valid_q <= iss_valid_d;
      iss_q       <= iss_d;
      count_q     <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
`ifdef RS_OLDEST_FIRST_EN
        age_q[i] <= age_d[i];
`endif
      end
    end
  end

  assign disp_ready_out  = (count_q != CW'(DEPTH));
  assign almost_full_out = (count_q >= CW'(DEPTH - FULL_MARGIN));
  assign count_out       = count_q;
  assign iss_valid_out   = iss_valid_q;
  assign iss_op_out      = iss_q.op;
  assign iss_tag_out     = iss_q.tag;
  assign iss_v1_out      = iss_q.v1;
  assign iss_v2_out      = iss_q.v2;
  assign iss_pc_out      = iss_q.pc;
  assign iss_imm_out     = iss_q.imm;

endmodule

// File: doc/rs_param.md
Name: rs_param

Overview:
- Parametrised reservation station; next generation of the single-ALU 16-entry RS.
- Sits between the dispatcher and one execution unit, and buffers up to DEPTH decoded instructions.
- Captures operand values from NCDB result broadcast channels and issues one ready entry per cycle through a registered valid/ready output stage.
- Adds over the previous RS: configurable depth, tag width and broadcast count; issue backpressure; occupancy count; optional oldest-first selection.

Parameters:
- DEPTH, 16, number of entries, power of two, 2..64.
- TAG_W, 5, ROB tag width; tag 0 means "value ready".
- XLEN, 32, operand, pc and imm width.
- OP_W, 6, opcode field width.
- NCDB, 2, number of result broadcast channels (ALU, LSU, ...).
- FULL_MARGIN, 1, almost_full threshold distance from DEPTH.

Ports:
- clk_in input 1 clock, rising edge.
- rst_in input 1 reset, asynchronous, active-low.
- rdy_in input 1 global enable; low freezes all state.
- flush_in input 1 synchronous rollback clear.
- disp_valid_in input 1 dispatch request.
- disp_ready_out output 1 entry available.
- disp_op_in input OP_W opcode.
- disp_q1_in, disp_q2_in input TAG_W producer tags.
- disp_v1_in, disp_v2_in input XLEN operand values.
- disp_pc_in, disp_imm_in input XLEN pc and immediate.
- disp_tag_in input TAG_W destination ROB tag.
- cdb_valid_in input NCDB per-channel valid.
- cdb_tag_in input NCDB*TAG_W; channel c occupies bits [c*TAG_W +: TAG_W].
- cdb_data_in input NCDB*XLEN; channel c occupies bits [c*XLEN +: XLEN].
- iss_valid_out output 1 issue register holds an instruction.
- iss_ready_in input 1 execution unit accepts.
- iss_op_out output OP_W; iss_v1_out, iss_v2_out, iss_pc_out, iss_imm_out output XLEN; iss_tag_out output TAG_W.
- count_out output $clog2(DEPTH+1) occupied entries, excluding the issue register.
- almost_full_out output 1 count_out >= DEPTH-FULL_MARGIN.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - All busy bits cleared; count_out=0; iss_valid_out=0.
  - All iss_* data outputs = 0; disp_ready_out=1; almost_full_out=0.
- Priority per edge: flush_in (acts regardless of rdy_in) > rdy_in=0 (hold everything) > normal operation.
- Flush: clears all busy bits and iss_valid_out and sets count to 0; a dispatch in the same cycle is dropped.
- disp_ready_out = (count != DEPTH). This is registered state only; a same-cycle issue is not credited.
- Dispatch is accepted when disp_valid_in && disp_ready_out. The entry is written into the lowest-index free slot.
- Dispatch forwarding: if disp_qX_in != 0 and matches a valid CDB channel this cycle, the entry stores the CDB data and Q=0.
- Capture: every cycle, each busy entry with Qx != 0 matching a valid channel's tag takes that channel's data and sets Qx=0.
  - If several channels carry the same tag, the lowest channel index wins.
  - CDB tag 0 is ignored.
- Ready entry: busy && Q1==0 && Q2==0.
- Issue register load:
  - Occurs when !iss_valid_out or (iss_valid_out && iss_ready_in), and a ready entry exists.
  - The selected entry's fields are copied to iss_*, iss_valid_out=1, and the entry's busy bit is cleared.
  - If no entry is ready and the register is being consumed, iss_valid_out drops to 0.
- Stall: while iss_valid_out && !iss_ready_in, all iss_* outputs hold stable.
- Latency:
  - Dispatch with both operands ready at edge E0 gives iss_valid_out high after E0+1.
  - A CDB wakeup at edge E gives issue after E+1.
  - Back-to-back issue sustains 1 per cycle.
- Entries only wake up through the capture rule above; the issue register itself is never updated by the CDB.
- count update: +1 on dispatch accept, -1 on issue load; simultaneous accept and load leaves count unchanged.
- Full (count=DEPTH): disp_ready_out=0 and the dispatch is ignored even if an issue frees a slot that edge.
- Empty: iss_valid_out falls after consumption and count_out=0.
- Reset mid-operation: immediate clear; outputs take their reset values asynchronously.

Optional Feature:
- Macro: RS_OLDEST_FIRST_EN.
- Defined: a DEPTH x DEPTH age matrix is maintained. On dispatch into slot k, row k is set to "younger than every currently busy entry". Issue selects the oldest ready entry.
- Undefined: no age matrix; issue selects the lowest-index ready entry (fixed priority).
- Both builds: identical ports and timing.

Test Plan:
- Reset then dispatch op=0x05, q1=q2=0, v1=3, v2=4, tag=7 with iss_ready_in=1 -> iss_valid_out=1 one cycle later; iss_v1_out=3, iss_v2_out=4, iss_tag_out=7; count_out returns to 0.
- Dispatch q1=9 (v1 junk) tag=2, then CDB ch1 valid tag=9 data=0xDEADBEEF -> entry issues the cycle after capture with iss_v1_out=0xDEADBEEF.
- Same-cycle forwarding: dispatch q2=4 while CDB ch0 broadcasts tag 4, data=0x11 -> issued with iss_v2_out=0x11 and no further wait.
- Fill 16 entries with q1=31 and iss_ready_in=0 -> after 16 accepts disp_ready_out=0, almost_full_out=1 from count 15; a 17th request is ignored; broadcast tag 31 drains all 16 in order under iss_ready_in=1.
- Backpressure: hold iss_ready_in=0 for 5 cycles with 2 ready entries -> iss_* stable, count_out=1; release -> the second issues on the next edge.
- Flush with 6 busy entries and iss_valid_out=1 while dispatching -> next cycle count_out=0, iss_valid_out=0, the dispatch is dropped. With RS_OLDEST_FIRST_EN: slots 3 then 1 dispatched, both woken together -> slot 3 issues first.
